// File: rtl/romload_writer_pkg.sv
// Shared definitions for the ROM-load stream writer: load-mode encodings,
// controller states and the halfword+strobe record carried through the FIFO.
package romload_writer_pkg;

  localparam logic [2:0] LOAD_IDLE    = 3'd0;
  localparam logic [2:0] LOAD_ROM     = 3'd1;
  localparam logic [2:0] LOAD_CARTRAM = 3'd2;
  localparam logic [2:0] LOAD_CONFIG  = 3'd3;
  localparam logic [2:0] LOAD_BIOS    = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [1:0]  strb;
    logic [15:0] data;
  } hword_t;

  localparam int HWORD_W = $bits(hword_t);

  // Encodings 5-7 are unused by the loader and behave exactly like idle.
  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m > LOAD_BIOS) ? LOAD_IDLE : m;
  endfunction

  function automatic logic is_mem_mode(input logic [2:0] m);
    return (m == LOAD_ROM) || (m == LOAD_CARTRAM) || (m == LOAD_BIOS);
  endfunction

endpackage

// File: rtl/romload_fifo.sv
// Synchronous FIFO for halfword write records; a push into a full FIFO is
// still taken when a pop happens in the same cycle.
module romload_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/romload_writer.sv
// Packs a byte-wide loading stream into halfword memory writes with a
// valid/ready port, and captures the 4-byte configuration block.
module romload_writer
  import romload_writer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 25,
  parameter int                    FIFO_DEPTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BIOS_BASE    = 25'h1FC0000,
  parameter logic [ADDR_WIDTH-1:0] CARTRAM_BASE = 25'h1F80000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            rom_loading,
  input  logic [7:0]            rom_do,
  input  logic                  rom_do_valid,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_wstrb,
  output logic                  busy,
  output logic                  load_done,
  output logic [ADDR_WIDTH-1:0] rom_size,
  output logic [31:0]           cfg_word,
  output logic                  overflow
);

  function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic [2:0] m);
    logic [ADDR_WIDTH-1:0] b;
    case (m)
      LOAD_CARTRAM: b = CARTRAM_BASE;
      LOAD_BIOS:    b = BIOS_BASE;
      default:      b = '0;
    endcase
    return {b[ADDR_WIDTH-1:1], 1'b0};
  endfunction

  state_e                state_q;
  logic [2:0]            prev_mode_q;
  logic [2:0]            load_mode_q;
  logic [2:0]            pend_mode_q;
  logic                  pend_start_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            byte_q;
  logic                  stage_vld_q;
  hword_t                stage_q;
  logic                  mem_valid_q;
  logic [15:0]           wdata_q;
  logic [1:0]            wstrb_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [ADDR_WIDTH-1:0] rom_size_q;
  logic [31:0]           cfg_q;
  logic [2:0]            cfg_cnt_q;

  logic [2:0] mode_now;
  logic [2:0] new_mode;
  logic       mode_edge;
  logic       restart;
  logic       start;
  logic       accept_byte;
  logic [2:0] cfg_idx;
  logic       cfg_wr;
  logic [2:0] cfg_cnt_d;

  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_clr;
  logic   fifo_full;
  logic   fifo_empty;
  hword_t fifo_rd;

  assign mode_now    = norm_mode(rom_loading);
  assign mode_edge   = is_mem_mode(mode_now) && (mode_now != prev_mode_q);
  assign restart     = (state_q == ST_LOAD) && is_mem_mode(mode_now) &&
                       (mode_now != load_mode_q);
  assign start       = restart ||
                       ((state_q == ST_IDLE) && (pend_start_q || mode_edge));
  assign new_mode    = ((state_q == ST_IDLE) && pend_start_q) ? pend_mode_q : mode_now;
  assign accept_byte = (state_q == ST_LOAD) && !restart && rom_do_valid &&
                       (mode_now == load_mode_q);

  // The config byte index restarts whenever mode 3 is freshly entered.
  assign cfg_idx   = (prev_mode_q == LOAD_CONFIG) ? cfg_cnt_q : 3'd0;
  assign cfg_wr    = (mode_now == LOAD_CONFIG) && rom_do_valid && !cfg_idx[2];
  assign cfg_cnt_d = cfg_idx + {2'b00, cfg_wr};

  assign fifo_clr  = restart;
  assign fifo_push = stage_vld_q && !fifo_clr;
  assign fifo_pop  = mem_valid_q && mem_ready;

  romload_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (HWORD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (stage_q),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_mode_q  <= LOAD_IDLE;
      load_mode_q  <= LOAD_IDLE;
      pend_mode_q  <= LOAD_IDLE;
      pend_start_q <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      byte_q       <= '0;
      stage_vld_q  <= 1'b0;
      stage_q      <= '0;
      mem_valid_q  <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rom_size_q   <= '0;
      cfg_q        <= '0;
      cfg_cnt_q    <= '0;
    end else begin
      prev_mode_q <= mode_now;
      done_q      <= 1'b0;
      stage_vld_q <= 1'b0;

      if (mode_now == LOAD_CONFIG) cfg_cnt_q <= cfg_cnt_d;
      if (cfg_wr) cfg_q[{cfg_idx[1:0], 3'b000} +: 8] <= rom_do;
      if ((prev_mode_q == LOAD_CONFIG) && (mode_now != LOAD_CONFIG)) done_q <= 1'b1;

      // Request is dropped for one cycle after each acceptance before the next head is offered.
      if (fifo_pop) begin
        mem_valid_q <= 1'b0;
        addr_q      <= addr_q + ADDR_WIDTH'(2);
      end else if (!mem_valid_q && !fifo_empty) begin
        mem_valid_q <= 1'b1;
        wdata_q     <= fifo_rd.data;
        wstrb_q     <= fifo_rd.strb;
      end

      if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
        end
        ST_LOAD: begin
          if (!restart && (mode_now != load_mode_q)) begin
            state_q <= ST_FLUSH;
            if (cnt_q[0]) begin
              stage_vld_q <= 1'b1;
              stage_q     <= {2'b01, 8'h00, byte_q};
            end
          end else if (accept_byte) begin
            cnt_q <= cnt_q + ADDR_WIDTH'(1);
            if (!cnt_q[0]) begin
              byte_q <= rom_do;
            end else begin
              stage_vld_q <= 1'b1;
              stage_q     <= {2'b11, rom_do, byte_q};
            end
          end
        end
        ST_FLUSH: begin
          if (mode_edge) begin
            pend_start_q <= 1'b1;
            pend_mode_q  <= mode_now;
          end
          if (fifo_empty && !mem_valid_q && !stage_vld_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            if (load_mode_q == LOAD_ROM) rom_size_q <= cnt_q;
          end
        end
        ST_DONE: begin
          if (mode_edge) begin
            pend_start_q <= 1'b1;
            pend_mode_q  <= mode_now;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (start) begin
        state_q      <= ST_LOAD;
        load_mode_q  <= new_mode;
        addr_q       <= base_addr(new_mode);
        mem_valid_q  <= 1'b0;
        stage_vld_q  <= 1'b0;
        ovf_q        <= 1'b0;
        busy_q       <= 1'b1;
        pend_start_q <= 1'b0;
        byte_q       <= rom_do;
        cnt_q        <= (rom_do_valid && (mode_now == new_mode)) ? ADDR_WIDTH'(1) : '0;
      end
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign rom_size  = rom_size_q;
  assign cfg_word  = cfg_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_romload_writer.sv
// Directed bench for romload_writer: table of complete loads plus hand-written
// sequences for config capture, overflow, mode switch and reset mid-write.
module tb_romload_writer;

  logic        clk;
  logic        reset;
  logic [2:0]  rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic        mem_valid;
  logic        mem_ready;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_wstrb;
  logic        busy;
  logic        load_done;
  logic [24:0] rom_size;
  logic [31:0] cfg_word;
  logic        overflow;

  romload_writer dut (
    .clk          (clk),
    .reset        (reset),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .busy         (busy),
    .load_done    (load_done),
    .rom_size     (rom_size),
    .cfg_word     (cfg_word),
    .overflow     (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int valid_cyc = 0;
  int busy_cyc = 0;
  logic stall = 1'b0;
  logic force_ready = 1'b0;
  int vcnt = 0;
  logic [24:0] wa [$];
  logic [15:0] wd [$];
  logic [1:0]  ws [$];

  typedef struct {
    logic [2:0]  mode;
    int          nb;
    logic [47:0] bytes;
    int          nwr;
    logic [24:0] a0;
    logic [15:0] d0;
    logic [1:0]  s0;
    logic [15:0] dl;
    logic [1:0]  sl;
    logic [24:0] rsz;
  } vec_t;

  vec_t tbl [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory slave: ready one cycle after valid is seen, unless stalled.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        mem_ready = 1'b1;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        vcnt = 0;
      end else if (mem_valid && !stall) begin
        if (vcnt >= 1) mem_ready = 1'b1;
        else vcnt++;
      end else if (!mem_valid) begin
        vcnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (load_done) done_cnt++;
    if (mem_valid) valid_cyc++;
    if (busy) busy_cyc++;
    if (!reset && mem_valid && mem_ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      ws.push_back(mem_wstrb);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 3000000)", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_wr(input string nm, input int idx, input logic [24:0] a,
                          input logic [15:0] d, input logic [1:0] s);
    if (idx < wa.size()) begin
      check({nm, "_addr"}, 64'(wa[idx]), 64'(a));
      check({nm, "_data"}, 64'(wd[idx]), 64'(d));
      check({nm, "_strb"}, 64'(ws[idx]), 64'(s));
    end else begin
      check({nm, "_present"}, 64'(wa.size()), 64'(idx + 1));
    end
  endtask

  task automatic stream(input logic [2:0] mode, input int nb, input logic [511:0] bytes,
                        input int burst);
    rom_loading = mode;
    @(posedge clk); #1;
    for (int i = 0; i < nb; i++) begin
      rom_do       = bytes[8*i +: 8];
      rom_do_valid = 1'b1;
      @(posedge clk); #1;
      if (burst > 0 && (i % burst) == burst - 1) begin
        rom_do_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    rom_do_valid = 1'b0;
  endtask

  task automatic finish_load(input string nm, input int d0);
    int k;
    rom_loading = 3'd0;
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_done_seen"}, 64'(done_cnt != d0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, wb, vc0, bc0, k;
    logic [511:0] ob;

    tbl[0] = '{3'd1, 4, 48'h0000_4433_2211, 2, 25'h0000000, 16'h2211, 2'b11, 16'h4433, 2'b11, 25'd4};
    tbl[1] = '{3'd4, 5, 48'h00EE_DDCC_BBAA, 3, 25'h1FC0000, 16'hBBAA, 2'b11, 16'h00EE, 2'b01, 25'd4};
    tbl[2] = '{3'd2, 3, 48'h0000_007C_6B5A, 2, 25'h1F80000, 16'h6B5A, 2'b11, 16'h007C, 2'b01, 25'd4};
    tbl[3] = '{3'd1, 1, 48'h0000_0000_0099, 1, 25'h0000000, 16'h0099, 2'b01, 16'h0099, 2'b01, 25'd1};
    tbl[4] = '{3'd1, 6, 48'h0605_0403_0201, 3, 25'h0000000, 16'h0201, 2'b11, 16'h0605, 2'b11, 25'd6};

    reset = 1'b1;
    rom_loading = 3'd0;
    rom_do = 8'h00;
    rom_do_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_load_done", 64'(load_done), 64'(0));
    check("rst_rom_size", 64'(rom_size), 64'(0));
    check("rst_cfg_word", 64'(cfg_word), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      wb = wa.size();
      stream(tbl[i].mode, tbl[i].nb, 512'(tbl[i].bytes), 4);
      check($sformatf("v%0d_busy_during", i), 64'(busy), 64'(1));
      finish_load($sformatf("v%0d", i), d0);
      check($sformatf("v%0d_nwrites", i), 64'(wa.size() - wb), 64'(tbl[i].nwr));
      for (int j = 0; j < tbl[i].nwr; j++) begin
        if (wb + j < wa.size())
          check($sformatf("v%0d_addr%0d", i, j), 64'(wa[wb + j]), 64'(tbl[i].a0 + 25'(2 * j)));
      end
      check_wr($sformatf("v%0d_first", i), wb, tbl[i].a0, tbl[i].d0, tbl[i].s0);
      check_wr($sformatf("v%0d_last", i), wb + tbl[i].nwr - 1,
               tbl[i].a0 + 25'(2 * (tbl[i].nwr - 1)), tbl[i].dl, tbl[i].sl);
      check($sformatf("v%0d_rom_size", i), 64'(rom_size), 64'(tbl[i].rsz));
      check($sformatf("v%0d_done_pulses", i), 64'(done_cnt - d0), 64'(1));
      check($sformatf("v%0d_busy_after", i), 64'(busy), 64'(0));
      check($sformatf("v%0d_overflow", i), 64'(overflow), 64'(0));
    end

    // Configuration capture
    d0 = done_cnt; vc0 = valid_cyc; bc0 = busy_cyc;
    stream(3'd3, 5, 512'(48'h0000_0504_0302_01), 4);
    rom_loading = 3'd0;
    @(posedge clk); #1;
    check("cfg_done_pulse", 64'(load_done), 64'(1));
    @(posedge clk); #1;
    check("cfg_done_single", 64'(load_done), 64'(0));
    check("cfg_word", 64'(cfg_word), 64'(32'h0403_0201));
    check("cfg_no_mem_valid", 64'(valid_cyc - vc0), 64'(0));
    check("cfg_no_busy", 64'(busy_cyc - bc0), 64'(0));
    check("cfg_done_count", 64'(done_cnt - d0), 64'(1));

    // Overflow with memory stalled
    ob = '0;
    for (int k2 = 0; k2 < 40; k2++) ob[8*k2 +: 8] = 8'(k2 + 1);
    d0 = done_cnt; wb = wa.size();
    stall = 1'b1;
    stream(3'd1, 40, ob, 0);
    check("ovf_set", 64'(overflow), 64'(1));
    repeat (160) @(posedge clk);
    #1;
    check("ovf_valid_held", 64'(mem_valid), 64'(1));
    check("ovf_no_writes_yet", 64'(wa.size() - wb), 64'(0));
    stall = 1'b0;
    finish_load("ovf", d0);
    check("ovf_nwrites", 64'(wa.size() - wb), 64'(8));
    for (int j = 0; j < 8; j++)
      check_wr($sformatf("ovf_w%0d", j), wb + j, 25'(2 * j),
               {8'(2 * j + 2), 8'(2 * j + 1)}, 2'b11);
    check("ovf_sticky", 64'(overflow), 64'(1));
    check("ovf_rom_size", 64'(rom_size), 64'(40));

    // Direct switch from ROM to cart RAM with queued halfwords
    d0 = done_cnt; wb = wa.size();
    stall = 1'b1;
    stream(3'd1, 6, 512'(48'h1615_1413_1211), 4);
    repeat (3) @(posedge clk);
    #1;
    check("sw_valid_before", 64'(mem_valid), 64'(1));
    rom_loading = 3'd2;
    @(posedge clk); #1;
    check("sw_valid_dropped", 64'(mem_valid), 64'(0));
    check("sw_addr_base", 64'(mem_addr), 64'(25'h1F80000));
    check("sw_busy", 64'(busy), 64'(1));
    check("sw_ovf_cleared", 64'(overflow), 64'(0));
    stall = 1'b0;
    stream(3'd2, 2, 512'(16'hC2C1), 4);
    finish_load("sw", d0);
    check("sw_nwrites", 64'(wa.size() - wb), 64'(1));
    check_wr("sw_w0", wb, 25'h1F80000, 16'hC2C1, 2'b11);
    check("sw_done_pulses", 64'(done_cnt - d0), 64'(1));

    // Reset while a write is outstanding
    wb = wa.size();
    stream(3'd1, 4, 512'(32'h2423_2221), 4);
    k = 0;
    while (wa.size() == wb && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("rw_first_accepted", 64'(wa.size() - wb), 64'(1));
    stall = 1'b1;
    k = 0;
    while (!mem_valid && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("rw_second_valid", 64'(mem_valid), 64'(1));
    check("rw_second_addr", 64'(mem_addr), 64'(2));
    reset = 1'b1;
    force_ready = 1'b1;
    rom_loading = 3'd0;
    @(posedge clk); #1;
    check("rw_mem_valid", 64'(mem_valid), 64'(0));
    check("rw_mem_addr", 64'(mem_addr), 64'(0));
    check("rw_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rw_mem_wstrb", 64'(mem_wstrb), 64'(0));
    check("rw_busy", 64'(busy), 64'(0));
    check("rw_load_done", 64'(load_done), 64'(0));
    check("rw_rom_size", 64'(rom_size), 64'(0));
    check("rw_cfg_word", 64'(cfg_word), 64'(0));
    check("rw_overflow", 64'(overflow), 64'(0));
    check("rw_no_extra_write", 64'(wa.size() - wb), 64'(1));
    reset = 1'b0;
    force_ready = 1'b0;
    stall = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    stream(3'd1, 2, 512'(16'h3231), 4);
    finish_load("rw", d0);
    check("rw_nwrites", 64'(wa.size() - wb), 64'(2));
    check_wr("rw_after", wb + 1, 25'h0000000, 16'h3231, 2'b11);
    check("rw_rom_size_after", 64'(rom_size), 64'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
